// File: rtl/common_pkg.sv
// Shared pipeline types for the writeback stage: result-source and
// load-size encodings, register file geometry and the load fault rule.
package common;

  localparam int REGISTER_FILE_SIZE = 32;
  localparam int REG_ID_W           = $clog2(REGISTER_FILE_SIZE);
  localparam int XLEN               = 32;

  // Source of the value written back to rd.
  typedef enum logic [1:0] {
    WB_SEL_ALU  = 2'd0,
    WB_SEL_MEM  = 2'd1,
    WB_SEL_PC4  = 2'd2,
    WB_SEL_RSVD = 2'd3
  } wb_sel_t;

  // Width of a load access.
  typedef enum logic [1:0] {
    MEM_SIZE_BYTE = 2'd0,
    MEM_SIZE_HALF = 2'd1,
    MEM_SIZE_WORD = 2'd2,
    MEM_SIZE_RSVD = 2'd3
  } mem_size_t;

  // A load faults when it is not naturally aligned or uses the reserved size.
  function automatic logic load_faults(mem_size_t size, logic [1:0] addr_lo);
    logic f;
    f = 1'b0;
    case (size)
      MEM_SIZE_BYTE: f = 1'b0;
      MEM_SIZE_HALF: f = addr_lo[0];
      MEM_SIZE_WORD: f = (addr_lo != 2'b00);
      default:       f = 1'b1;
    endcase
    return f;
  endfunction

endpackage

// File: rtl/writeback_stage_if.sv
// Signal bundle between the memory stage and the writeback stage, plus the
// register-file write port and retire/fault pulses.
//
// Handshake: an instruction transfers at a rising clk edge where
// in_valid && in_ready are both high. in_ready depends only on hold, never on
// in_valid, so the producer may raise in_valid without waiting for in_ready
// and must keep its payload stable until the transfer edge.
interface writeback_stage_if;
  import common::*;

  logic                in_valid;
  logic                in_ready;
  logic                hold;
  logic                in_reg_write;
  logic [REG_ID_W-1:0] in_rd_id;
  logic [1:0]          in_wb_sel;
  logic [XLEN-1:0]     in_alu_result;
  logic [XLEN-1:0]     in_pc;
  logic [XLEN-1:0]     in_mem_rdata;
  logic [1:0]          in_mem_size;
  logic                in_mem_unsigned;
  logic                write_en;
  logic [REG_ID_W-1:0] write_id;
  logic [XLEN-1:0]     write_data;
  logic                retire_valid;
  logic                misalign_err;

  // Memory-stage side: produces instructions, observes the stage results.
  modport master (
    output in_valid, hold, in_reg_write, in_rd_id, in_wb_sel, in_alu_result,
           in_pc, in_mem_rdata, in_mem_size, in_mem_unsigned,
    input  in_ready, write_en, write_id, write_data, retire_valid, misalign_err
  );

  // Writeback-stage side.
  modport slave (
    input  in_valid, hold, in_reg_write, in_rd_id, in_wb_sel, in_alu_result,
           in_pc, in_mem_rdata, in_mem_size, in_mem_unsigned,
    output in_ready, write_en, write_id, write_data, retire_valid, misalign_err
  );

endinterface

// File: rtl/writeback_stage_load_formatter.sv
// Extracts the addressed byte/half from an aligned load word and extends it
// to 32 bits (sign or zero). Purely combinational.
module load_formatter
  import common::*;
(
  input  logic [XLEN-1:0] rdata_i,
  input  logic [1:0]      addr_lo_i,
  input  mem_size_t       size_i,
  input  logic            unsigned_i,
  output logic [XLEN-1:0] data_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic        sign_en;

  assign sign_en = !unsigned_i;

  // Lane selection by the low address bits.
  always_comb begin
    byte_sel = rdata_i[7:0];
    case (addr_lo_i)
      2'd0: byte_sel = rdata_i[7:0];
      2'd1: byte_sel = rdata_i[15:8];
      2'd2: byte_sel = rdata_i[23:16];
      2'd3: byte_sel = rdata_i[31:24];
      default: byte_sel = rdata_i[7:0];
    endcase
    half_sel = addr_lo_i[1] ? rdata_i[31:16] : rdata_i[15:0];
  end

  // Extension to full width; reserved size passes the word through (it faults anyway).
  always_comb begin
    data_o = rdata_i;
    case (size_i)
      MEM_SIZE_BYTE: data_o = {{24{sign_en & byte_sel[7]}}, byte_sel};
      MEM_SIZE_HALF: data_o = {{16{sign_en & half_sel[15]}}, half_sel};
      default:       data_o = rdata_i;
    endcase
  end

endmodule

// File: rtl/writeback_stage.sv
// Writeback stage: one-slot register between the memory stage and the
// register file. Selects the result, formats loads, flags misaligned loads,
// issues the register write and counts retired instructions.
module writeback_stage
  import common::*;
#(
  parameter int INSTRET_W = 64
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic                 hold,
  input  logic                 in_reg_write,
  input  logic [4:0]           in_rd_id,
  input  logic [1:0]           in_wb_sel,
  input  logic [31:0]          in_alu_result,
  input  logic [31:0]          in_pc,
  input  logic [31:0]          in_mem_rdata,
  input  logic [1:0]           in_mem_size,
  input  logic                 in_mem_unsigned,
  output logic                 write_en,
  output logic [4:0]           write_id,
  output logic [31:0]          write_data,
  output logic                 retire_valid,
  output logic                 misalign_err,
  output logic [INSTRET_W-1:0] instret
);

  wb_sel_t        sel;
  mem_size_t      size;
  logic [31:0]    load_data;
  logic [31:0]    result;
  logic           accept;
  logic           fault;
  logic           writes_rd;

  logic           slot_valid_q, slot_valid_d;
  logic           slot_write_q, slot_write_d;
  logic           slot_fault_q, slot_fault_d;
  logic [4:0]     write_id_q, write_id_d;
  logic [31:0]    write_data_q, write_data_d;
  logic [INSTRET_W-1:0] instret_q, instret_d;

  // Hold only blocks new acceptance; a slot already filled still completes.
  assign in_ready = !hold;
  assign accept   = in_valid && in_ready;
  assign sel      = wb_sel_t'(in_wb_sel);
  assign size     = mem_size_t'(in_mem_size);

  load_formatter u_load_formatter (
    .rdata_i    (in_mem_rdata),
    .addr_lo_i  (in_alu_result[1:0]),
    .size_i     (size),
    .unsigned_i (in_mem_unsigned),
    .data_o     (load_data)
  );

  // Result selection and fault detection on the incoming instruction.
  always_comb begin
    result = in_alu_result;
    case (sel)
      WB_SEL_ALU: result = in_alu_result;
      WB_SEL_MEM: result = load_data;
      WB_SEL_PC4: result = in_pc + 32'd4;
      default:    result = in_alu_result;
    endcase
    fault     = (sel == WB_SEL_MEM) && load_faults(size, in_alu_result[1:0]);
    writes_rd = in_reg_write && (in_rd_id != 5'd0);
  end

  // Slot next state; write_id/write_data only move on a real write so they
  // keep their last values while write_en is low.
  always_comb begin
    slot_valid_d = accept;
    slot_write_d = accept && writes_rd;
    slot_fault_d = accept && fault;
    write_id_d   = write_id_q;
    write_data_d = write_data_q;
    if (accept && writes_rd && !fault) begin
      write_id_d   = in_rd_id;
      write_data_d = result;
    end
    instret_d = instret_q;
    if (retire_valid) begin
      instret_d = instret_q + INSTRET_W'(1);
    end
  end

  // Stage registers; asynchronous reset empties the slot and clears the count.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      slot_valid_q <= 1'b0;
      slot_write_q <= 1'b0;
      slot_fault_q <= 1'b0;
      write_id_q   <= 5'd0;
      write_data_q <= 32'd0;
      instret_q    <= '0;
    end else begin
      slot_valid_q <= slot_valid_d;
      slot_write_q <= slot_write_d;
      slot_fault_q <= slot_fault_d;
      write_id_q   <= write_id_d;
      write_data_q <= write_data_d;
      instret_q    <= instret_d;
    end
  end

  assign write_en     = slot_valid_q && slot_write_q && !slot_fault_q;
  assign retire_valid = slot_valid_q && !slot_fault_q;
  assign misalign_err = slot_valid_q && slot_fault_q;
  assign write_id     = write_id_q;
  assign write_data   = write_data_q;
  assign instret      = instret_q;

endmodule

// File: tb/tb_writeback_stage.sv
// Directed bench for writeback_stage: load formatting, faults, PC+4 wrap,
// x0 suppression, hold behaviour, instret wrap and asynchronous reset.
module tb_writeback_stage;
  import common::*;

  logic clk;
  logic reset_n;

  writeback_stage_if bus();

  logic [63:0] instret;
  logic [3:0]  instret_small;
  logic        s_in_ready, s_write_en, s_retire, s_misalign;
  logic [4:0]  s_write_id;
  logic [31:0] s_write_data;

  int n_checks = 0;
  int n_fail   = 0;
  logic [63:0] exp_instret;
  logic [3:0]  exp_small;

  typedef struct {
    logic [1:0]  sel;
    logic [1:0]  size;
    logic        uns;
    logic [31:0] addr;
    logic [31:0] rdata;
    logic        exp_fault;
    logic [31:0] exp_data;
  } vec_t;
  vec_t vecs[11];

  // Clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  writeback_stage #(.INSTRET_W(64)) dut (
    .clk(clk), .reset_n(reset_n),
    .in_valid(bus.in_valid), .in_ready(bus.in_ready), .hold(bus.hold),
    .in_reg_write(bus.in_reg_write), .in_rd_id(bus.in_rd_id),
    .in_wb_sel(bus.in_wb_sel), .in_alu_result(bus.in_alu_result),
    .in_pc(bus.in_pc), .in_mem_rdata(bus.in_mem_rdata),
    .in_mem_size(bus.in_mem_size), .in_mem_unsigned(bus.in_mem_unsigned),
    .write_en(bus.write_en), .write_id(bus.write_id),
    .write_data(bus.write_data), .retire_valid(bus.retire_valid),
    .misalign_err(bus.misalign_err), .instret(instret)
  );

  writeback_stage #(.INSTRET_W(4)) dut_small (
    .clk(clk), .reset_n(reset_n),
    .in_valid(bus.in_valid), .in_ready(s_in_ready), .hold(bus.hold),
    .in_reg_write(bus.in_reg_write), .in_rd_id(bus.in_rd_id),
    .in_wb_sel(bus.in_wb_sel), .in_alu_result(bus.in_alu_result),
    .in_pc(bus.in_pc), .in_mem_rdata(bus.in_mem_rdata),
    .in_mem_size(bus.in_mem_size), .in_mem_unsigned(bus.in_mem_unsigned),
    .write_en(s_write_en), .write_id(s_write_id),
    .write_data(s_write_data), .retire_valid(s_retire),
    .misalign_err(s_misalign), .instret(instret_small)
  );

  // Driver tasks
  task automatic drive_instr(input logic rw, input logic [4:0] rd,
                             input logic [1:0] sel, input logic [31:0] alu,
                             input logic [31:0] pc, input logic [31:0] rdata,
                             input logic [1:0] size, input logic uns);
    bus.in_valid        = 1'b1;
    bus.in_reg_write    = rw;
    bus.in_rd_id        = rd;
    bus.in_wb_sel       = sel;
    bus.in_alu_result   = alu;
    bus.in_pc           = pc;
    bus.in_mem_rdata    = rdata;
    bus.in_mem_size     = size;
    bus.in_mem_unsigned = uns;
  endtask

  task automatic idle(input int n);
    bus.in_valid = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_reset();
    reset_n  = 1'b0;
    bus.hold = 1'b0;
    drive_instr(1'b1, 5'd9, WB_SEL_ALU, 32'h5555_5555, 32'h0, 32'h0, MEM_SIZE_WORD, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    n_checks++; if (bus.write_en !== 1'b0) begin n_fail++; $display("FAIL reset_write_en: got %0b expected 0", bus.write_en); end
    n_checks++; if (bus.write_id !== 5'd0) begin n_fail++; $display("FAIL reset_write_id: got %0d expected 0", bus.write_id); end
    n_checks++; if (bus.write_data !== 32'd0) begin n_fail++; $display("FAIL reset_write_data: got %h expected 0", bus.write_data); end
    n_checks++; if (bus.retire_valid !== 1'b0) begin n_fail++; $display("FAIL reset_retire: got %0b expected 0", bus.retire_valid); end
    n_checks++; if (bus.misalign_err !== 1'b0) begin n_fail++; $display("FAIL reset_misalign: got %0b expected 0", bus.misalign_err); end
    n_checks++; if (instret !== 64'd0) begin n_fail++; $display("FAIL reset_instret: got %0d expected 0", instret); end
    n_checks++; if (instret_small !== 4'd0) begin n_fail++; $display("FAIL reset_instret_small: got %0d expected 0", instret_small); end
    n_checks++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %0b expected 1", bus.in_ready); end
    bus.in_valid = 1'b0;
    reset_n      = 1'b1;
    exp_instret  = 64'd0;
    exp_small    = 4'd0;
    idle(1);
  endtask

  task automatic test_load_formats();
    vecs[0]  = '{WB_SEL_MEM, MEM_SIZE_BYTE, 1'b0, 32'h0000_1003, 32'h80FF_0000, 1'b0, 32'hFFFF_FF80};
    vecs[1]  = '{WB_SEL_MEM, MEM_SIZE_BYTE, 1'b1, 32'h0000_1003, 32'h80FF_0000, 1'b0, 32'h0000_0080};
    vecs[2]  = '{WB_SEL_MEM, MEM_SIZE_HALF, 1'b0, 32'h0000_2002, 32'h8001_1234, 1'b0, 32'hFFFF_8001};
    vecs[3]  = '{WB_SEL_MEM, MEM_SIZE_HALF, 1'b1, 32'h0000_2000, 32'h1234_F00D, 1'b0, 32'h0000_F00D};
    vecs[4]  = '{WB_SEL_MEM, MEM_SIZE_WORD, 1'b0, 32'h0000_3000, 32'hDEAD_BEEF, 1'b0, 32'hDEAD_BEEF};
    vecs[5]  = '{WB_SEL_MEM, MEM_SIZE_BYTE, 1'b0, 32'h0000_0001, 32'h0000_7F00, 1'b0, 32'h0000_007F};
    vecs[6]  = '{WB_SEL_MEM, MEM_SIZE_HALF, 1'b0, 32'h0000_2001, 32'h1111_2222, 1'b1, 32'h0};
    vecs[7]  = '{WB_SEL_MEM, MEM_SIZE_WORD, 1'b0, 32'h0000_3002, 32'h1111_2222, 1'b1, 32'h0};
    vecs[8]  = '{WB_SEL_MEM, MEM_SIZE_RSVD, 1'b0, 32'h0000_4000, 32'h1111_2222, 1'b1, 32'h0};
    vecs[9]  = '{WB_SEL_RSVD, MEM_SIZE_RSVD, 1'b0, 32'hCAFE_0001, 32'h1111_2222, 1'b0, 32'hCAFE_0001};
    vecs[10] = '{WB_SEL_ALU, MEM_SIZE_HALF, 1'b0, 32'h0BAD_F00D, 32'h1111_2222, 1'b0, 32'h0BAD_F00D};
    for (int i = 0; i < 11; i++) begin
      drive_instr(1'b1, 5'(10 + i), vecs[i].sel, vecs[i].addr, 32'h0,
                  vecs[i].rdata, vecs[i].size, vecs[i].uns);
      @(posedge clk);
      #1;
      if (vecs[i].exp_fault) begin
        n_checks++; if (bus.misalign_err !== 1'b1) begin n_fail++; $display("FAIL fmt%0d_misalign: got %0b expected 1", i, bus.misalign_err); end
        n_checks++; if (bus.write_en !== 1'b0) begin n_fail++; $display("FAIL fmt%0d_write_en: got %0b expected 0", i, bus.write_en); end
        n_checks++; if (bus.retire_valid !== 1'b0) begin n_fail++; $display("FAIL fmt%0d_retire: got %0b expected 0", i, bus.retire_valid); end
      end else begin
        exp_instret = exp_instret + 64'd1;
        exp_small   = exp_small + 4'd1;
        n_checks++; if (bus.write_en !== 1'b1) begin n_fail++; $display("FAIL fmt%0d_write_en: got %0b expected 1", i, bus.write_en); end
        n_checks++; if (bus.write_id !== 5'(10 + i)) begin n_fail++; $display("FAIL fmt%0d_write_id: got %0d expected %0d", i, bus.write_id, 10 + i); end
        n_checks++; if (bus.write_data !== vecs[i].exp_data) begin n_fail++; $display("FAIL fmt%0d_write_data: got %h expected %h", i, bus.write_data, vecs[i].exp_data); end
        n_checks++; if (bus.misalign_err !== 1'b0) begin n_fail++; $display("FAIL fmt%0d_misalign: got %0b expected 0", i, bus.misalign_err); end
      end
    end
    idle(2);
    n_checks++; if (instret !== exp_instret) begin n_fail++; $display("FAIL fmt_instret: got %0d expected %0d", instret, exp_instret); end
  endtask

  task automatic test_misalign();
    drive_instr(1'b1, 5'd3, WB_SEL_MEM, 32'h0000_2001, 32'h0, 32'hABCD_EF01, MEM_SIZE_HALF, 1'b0);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    n_checks++; if (bus.misalign_err !== 1'b1) begin n_fail++; $display("FAIL lh_misalign: got %0b expected 1", bus.misalign_err); end
    n_checks++; if (bus.write_en !== 1'b0) begin n_fail++; $display("FAIL lh_write_en: got %0b expected 0", bus.write_en); end
    n_checks++; if (bus.retire_valid !== 1'b0) begin n_fail++; $display("FAIL lh_retire: got %0b expected 0", bus.retire_valid); end
    @(posedge clk);
    #1;
    n_checks++; if (bus.misalign_err !== 1'b0) begin n_fail++; $display("FAIL lh_misalign_pulse: got %0b expected 0", bus.misalign_err); end
    idle(1);
    n_checks++; if (instret !== exp_instret) begin n_fail++; $display("FAIL lh_instret: got %0d expected %0d", instret, exp_instret); end
  endtask

  task automatic test_jal();
    drive_instr(1'b1, 5'd1, WB_SEL_PC4, 32'h0000_0000, 32'hFFFF_FFFC, 32'h0, MEM_SIZE_WORD, 1'b0);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    exp_instret  = exp_instret + 64'd1;
    exp_small    = exp_small + 4'd1;
    n_checks++; if (bus.write_en !== 1'b1) begin n_fail++; $display("FAIL jal_write_en: got %0b expected 1", bus.write_en); end
    n_checks++; if (bus.write_id !== 5'd1) begin n_fail++; $display("FAIL jal_write_id: got %0d expected 1", bus.write_id); end
    n_checks++; if (bus.write_data !== 32'h0000_0000) begin n_fail++; $display("FAIL jal_write_data: got %h expected 00000000", bus.write_data); end
    n_checks++; if (bus.retire_valid !== 1'b1) begin n_fail++; $display("FAIL jal_retire: got %0b expected 1", bus.retire_valid); end
  endtask

  task automatic test_alu_x0();
    drive_instr(1'b1, 5'd0, WB_SEL_ALU, 32'h0000_1234, 32'h0, 32'h0, MEM_SIZE_WORD, 1'b0);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    exp_instret  = exp_instret + 64'd1;
    exp_small    = exp_small + 4'd1;
    n_checks++; if (bus.write_en !== 1'b0) begin n_fail++; $display("FAIL x0_write_en: got %0b expected 0", bus.write_en); end
    n_checks++; if (bus.retire_valid !== 1'b1) begin n_fail++; $display("FAIL x0_retire: got %0b expected 1", bus.retire_valid); end
    n_checks++; if (bus.write_id !== 5'd1) begin n_fail++; $display("FAIL x0_write_id_stable: got %0d expected 1", bus.write_id); end
    n_checks++; if (bus.write_data !== 32'h0) begin n_fail++; $display("FAIL x0_write_data_stable: got %h expected 00000000", bus.write_data); end
    idle(2);
    n_checks++; if (instret !== exp_instret) begin n_fail++; $display("FAIL x0_instret: got %0d expected %0d", instret, exp_instret); end
  endtask

  task automatic test_hold();
    int writes;
    int retires;
    drive_instr(1'b1, 5'd5, WB_SEL_ALU, 32'h0000_AAAA, 32'h0, 32'h0, MEM_SIZE_WORD, 1'b0);
    @(posedge clk);
    #1;
    bus.hold = 1'b1;
    drive_instr(1'b1, 5'd6, WB_SEL_ALU, 32'h0000_BBBB, 32'h0, 32'h0, MEM_SIZE_WORD, 1'b0);
    exp_instret = exp_instret + 64'd1;
    exp_small   = exp_small + 4'd1;
    n_checks++; if (bus.write_en !== 1'b1) begin n_fail++; $display("FAIL hold_inflight_we: got %0b expected 1", bus.write_en); end
    n_checks++; if (bus.write_data !== 32'h0000_AAAA) begin n_fail++; $display("FAIL hold_inflight_data: got %h expected 0000aaaa", bus.write_data); end
    #1;
    n_checks++; if (bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL hold_in_ready: got %0b expected 0", bus.in_ready); end
    writes  = 0;
    retires = 0;
    repeat (3) begin
      @(posedge clk);
      #1;
      if (bus.write_en === 1'b1) writes++;
      if (bus.retire_valid === 1'b1) retires++;
    end
    n_checks++; if (writes !== 0) begin n_fail++; $display("FAIL hold_writes: got %0d expected 0", writes); end
    n_checks++; if (retires !== 0) begin n_fail++; $display("FAIL hold_retires: got %0d expected 0", retires); end
    n_checks++; if (bus.write_id !== 5'd5) begin n_fail++; $display("FAIL hold_write_id_stable: got %0d expected 5", bus.write_id); end
    bus.hold = 1'b0;
    #1;
    n_checks++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL release_in_ready: got %0b expected 1", bus.in_ready); end
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    exp_instret  = exp_instret + 64'd1;
    exp_small    = exp_small + 4'd1;
    n_checks++; if (bus.write_en !== 1'b1) begin n_fail++; $display("FAIL release_write_en: got %0b expected 1", bus.write_en); end
    n_checks++; if (bus.write_id !== 5'd6) begin n_fail++; $display("FAIL release_write_id: got %0d expected 6", bus.write_id); end
    n_checks++; if (bus.write_data !== 32'h0000_BBBB) begin n_fail++; $display("FAIL release_write_data: got %h expected 0000bbbb", bus.write_data); end
    @(posedge clk);
    #1;
    n_checks++; if (bus.write_en !== 1'b0) begin n_fail++; $display("FAIL release_single_write: got %0b expected 0", bus.write_en); end
    idle(1);
    n_checks++; if (instret !== exp_instret) begin n_fail++; $display("FAIL hold_instret: got %0d expected %0d", instret, exp_instret); end
  endtask

  task automatic test_back_to_back_wrap();
    int retires;
    reset_n = 1'b0;
    #2;
    reset_n     = 1'b1;
    exp_instret = 64'd0;
    exp_small   = 4'd0;
    retires     = 0;
    for (int i = 0; i < 17; i++) begin
      drive_instr(1'b1, 5'((i % 31) + 1), WB_SEL_ALU, 32'(i * 3 + 7), 32'h0, 32'h0, MEM_SIZE_WORD, 1'b0);
      @(posedge clk);
      #1;
      exp_instret = exp_instret + 64'd1;
      exp_small   = exp_small + 4'd1;
      if (bus.retire_valid === 1'b1) retires++;
      n_checks++; if (bus.write_data !== 32'(i * 3 + 7)) begin n_fail++; $display("FAIL b2b%0d_write_data: got %h expected %h", i, bus.write_data, 32'(i * 3 + 7)); end
    end
    idle(2);
    n_checks++; if (retires !== 17) begin n_fail++; $display("FAIL b2b_retires: got %0d expected 17", retires); end
    n_checks++; if (instret_small !== 4'd1) begin n_fail++; $display("FAIL wrap_instret_small: got %0d expected 1", instret_small); end
    n_checks++; if (instret_small !== exp_small) begin n_fail++; $display("FAIL wrap_instret_model: got %0d expected %0d", instret_small, exp_small); end
    n_checks++; if (instret !== 64'd17) begin n_fail++; $display("FAIL b2b_instret: got %0d expected 17", instret); end
  endtask

  task automatic test_reset_mid();
    drive_instr(1'b1, 5'd7, WB_SEL_ALU, 32'h0000_7777, 32'h0, 32'h0, MEM_SIZE_WORD, 1'b0);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    n_checks++; if (bus.write_en !== 1'b1) begin n_fail++; $display("FAIL midrst_pre_we: got %0b expected 1", bus.write_en); end
    #2;
    reset_n = 1'b0;
    #1;
    n_checks++; if (bus.write_en !== 1'b0) begin n_fail++; $display("FAIL midrst_write_en: got %0b expected 0", bus.write_en); end
    n_checks++; if (bus.write_id !== 5'd0) begin n_fail++; $display("FAIL midrst_write_id: got %0d expected 0", bus.write_id); end
    n_checks++; if (bus.write_data !== 32'd0) begin n_fail++; $display("FAIL midrst_write_data: got %h expected 0", bus.write_data); end
    n_checks++; if (bus.retire_valid !== 1'b0) begin n_fail++; $display("FAIL midrst_retire: got %0b expected 0", bus.retire_valid); end
    n_checks++; if (instret !== 64'd0) begin n_fail++; $display("FAIL midrst_instret: got %0d expected 0", instret); end
    n_checks++; if (instret_small !== 4'd0) begin n_fail++; $display("FAIL midrst_instret_small: got %0d expected 0", instret_small); end
    @(posedge clk);
    #1;
    n_checks++; if (bus.write_en !== 1'b0) begin n_fail++; $display("FAIL midrst_held_we: got %0b expected 0", bus.write_en); end
    reset_n = 1'b1;
    drive_instr(1'b1, 5'd8, WB_SEL_ALU, 32'h0000_8888, 32'h0, 32'h0, MEM_SIZE_WORD, 1'b0);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    n_checks++; if (bus.write_en !== 1'b1) begin n_fail++; $display("FAIL post_rst_write_en: got %0b expected 1", bus.write_en); end
    n_checks++; if (bus.write_id !== 5'd8) begin n_fail++; $display("FAIL post_rst_write_id: got %0d expected 8", bus.write_id); end
    n_checks++; if (bus.write_data !== 32'h0000_8888) begin n_fail++; $display("FAIL post_rst_write_data: got %h expected 00008888", bus.write_data); end
    idle(2);
    n_checks++; if (instret !== 64'd1) begin n_fail++; $display("FAIL post_rst_instret: got %0d expected 1", instret); end
  endtask

  // Main sequence and final report
  initial begin
    bus.in_valid = 1'b0;
    bus.hold     = 1'b0;
    reset_n      = 1'b0;
    test_reset();
    test_load_formats();
    test_misalign();
    test_jal();
    test_alu_x0();
    test_hold();
    test_back_to_back_wrap();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Watchdog against a stuck sequence.
  initial begin
    #50000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/writeback_stage.md
WRITEBACK_STAGE -- requirements
Module: writeback_stage

Interface
REQ-001 SHALL have parameter INSTRET_W, default 64, width of the retired-instruction counter.
REQ-002 SHALL have port clk, input, 1, single clock; all state on its rising edge.
REQ-003 SHALL have port reset_n, input, 1, reset that is asynchronous and active-low.
REQ-004 SHALL have port in_valid, input, 1, the memory stage presents an instruction.
REQ-005 SHALL have port in_ready, output, 1, the stage accepts an instruction this cycle.
REQ-006 SHALL have port hold, input, 1, pipeline freeze request.
REQ-007 SHALL have port in_reg_write, input, 1, the instruction writes rd.
REQ-008 SHALL have port in_rd_id, input, 5, destination register.
REQ-009 SHALL have port in_wb_sel, input, 2, result source (wb_sel_t): ALU / MEM / PC4 / reserved.
REQ-010 SHALL have port in_alu_result, input, 32, ALU result; load address when wb_sel=MEM.
REQ-011 SHALL have port in_pc, input, 32, instruction PC.
REQ-012 SHALL have port in_mem_rdata, input, 32, raw aligned load word.
REQ-013 SHALL have port in_mem_size, input, 2, load size (mem_size_t): BYTE / HALF / WORD / reserved.
REQ-014 SHALL have port in_mem_unsigned, input, 1, zero-extend instead of sign-extend.
REQ-015 SHALL have port write_en, output, 1, register file write strobe.
REQ-016 SHALL have port write_id, output, 5, register file write index.
REQ-017 SHALL have port write_data, output, 32, register file write data.
REQ-018 SHALL have port retire_valid, output, 1, one-cycle pulse per retired instruction.
REQ-019 SHALL have port misalign_err, output, 1, one-cycle pulse per faulting load.
REQ-020 SHALL have port instret, output, INSTRET_W, retired-instruction count.

Function
REQ-021 SHALL drive in_ready = !hold, combinationally; an instruction is accepted when in_valid && in_ready at a rising edge.
REQ-022 SHALL register each accepted instruction into a single stage slot and present its outputs in the cycle after acceptance, with one-cycle latency.
REQ-023 SHALL clear the slot valid bit at any edge where no instruction is accepted, so each instruction is presented for exactly one cycle.
REQ-024 SHALL select write_data as follows: ALU -> alu_result; PC4 -> pc+4 mod 2^32; MEM -> the formatted load; reserved -> alu_result.
REQ-025 SHALL format loads as follows: BYTE -> rdata byte at addr[1:0]; HALF -> rdata half at addr[1]; WORD -> rdata; extend to 32 bits by sign unless in_mem_unsigned.
REQ-026 SHALL flag a fault for a MEM instruction whose size is HALF with addr[0]=1, WORD with addr[1:0]!=0, or the reserved size.
REQ-027 SHALL pulse misalign_err on a faulting instruction and SHALL NOT assert write_en or retire_valid for it.
REQ-028 SHALL drive write_en = slot valid && reg_write && rd!=0 && !fault; a write to x0 is never issued.
REQ-029 SHALL hold write_id and write_data stable while write_en=0, retaining their last values.
REQ-030 SHALL pulse retire_valid for every valid, non-faulting instruction, including those with reg_write=0.
REQ-031 SHALL increment instret by 1 on each retire_valid cycle and wrap from all-ones to 0.
REQ-032 SHALL let an instruction already in the slot when hold rises complete its write and retire; hold only blocks new acceptance.

Reset
REQ-033 SHALL, while reset_n=0 and regardless of clk, force slot valid=0, write_en=0, write_id=0, write_data=0, retire_valid=0, misalign_err=0, and instret=0.
REQ-034 SHALL discard any instruction in the slot when reset asserts mid-operation; the instruction is not written and not counted.
REQ-035 SHALL accept a new instruction at the first rising edge after reset_n deasserts.

Structure
REQ-036 SHALL take wb_sel_t and mem_size_t enums from package common, alongside REGISTER_FILE_SIZE.
REQ-037 SHALL place load extraction and extension in one combinational sub-module, load_formatter.

Verification
REQ-038 SHALL cover LB, addr=0x1003, rdata=0x80FF_0000, signed -> write_data=0xFFFF_FF80, and LBU of the same -> 0x0000_0080, each one cycle after acceptance.
REQ-039 SHALL cover LH, addr=0x2001 -> misalign_err=1, write_en=0, retire_valid=0, instret unchanged.
REQ-040 SHALL cover JAL, pc=0xFFFF_FFFC, wb_sel=PC4, rd=1 -> write_en=1, write_id=1, write_data=0x0000_0000.
REQ-041 SHALL cover ALU op, rd=0, result 0x1234 -> write_en=0, retire_valid=1, instret+1.
REQ-042 SHALL cover hold=1 for 3 cycles with in_valid=1 -> in_ready=0 and no new write; the in-flight instruction retires once; after release the next instruction writes exactly once.
REQ-043 SHALL cover INSTRET_W=4 with 17 retires -> instret=1; reset_n pulsed low mid-cycle with a valid slot -> outputs zero immediately and no write occurs.
